// File: rtl/instr_fetch_if.sv
// Fetch-unit bus: instruction-memory handshake, decoder/ALU feedback and fetched-instruction outputs.
// IF_MISALIGN_TRAP_EN adds the sticky misalign flag.
interface instr_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        beq;
    logic        bge;
    logic        zero;
    logic        ge;
    logic [31:0] imm_b;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [6:0]  opcode;
    logic [2:0]  func3;
    logic        inst_valid;
    logic [31:0] retired;
`ifdef IF_MISALIGN_TRAP_EN
    logic        misalign;

    modport master (
        output imem_req, imem_addr, pc, inst, opcode, func3, inst_valid, retired, misalign,
        input  imem_ack, imem_rdata, stall, beq, bge, zero, ge, imm_b
    );
    modport slave (
        input  imem_req, imem_addr, pc, inst, opcode, func3, inst_valid, retired, misalign,
        output imem_ack, imem_rdata, stall, beq, bge, zero, ge, imm_b
    );
`else
    modport master (
        output imem_req, imem_addr, pc, inst, opcode, func3, inst_valid, retired,
        input  imem_ack, imem_rdata, stall, beq, bge, zero, ge, imm_b
    );
    modport slave (
        input  imem_req, imem_addr, pc, inst, opcode, func3, inst_valid, retired,
        output imem_ack, imem_rdata, stall, beq, bge, zero, ge, imm_b
    );
`endif
endinterface

// File: rtl/instr_fetch.sv
// Sequential RV32 instruction fetch: owns the PC, one outstanding imem request, branch-resolved next PC.
// IF_MISALIGN_TRAP_EN: misaligned next PC enters a sticky trap instead of being force-aligned.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic           clk,
    input logic           rst,
    instr_fetch_if.master bus
);

`ifdef IF_MISALIGN_TRAP_EN
    typedef enum logic [1:0] {StReset, StFetch, StExec, StTrap} state_e;
`else
    typedef enum logic [1:0] {StReset, StFetch, StExec} state_e;
`endif

    state_e      state_q;
    logic [31:0] pc_q;
    logic [31:0] inst_q;
    logic [31:0] retired_q;
    logic        req_q;
    logic        valid_q;
    logic        taken_d;
    logic [31:0] target_d;
    logic [31:0] next_pc_d;
`ifdef IF_MISALIGN_TRAP_EN
    logic        misalign_q;
`endif

    always_comb begin
        taken_d  = (bus.beq & bus.zero) | (bus.bge & bus.ge);
        target_d = taken_d ? (pc_q + bus.imm_b) : (pc_q + 32'd4);
`ifdef IF_MISALIGN_TRAP_EN
        next_pc_d = target_d;
`else
        next_pc_d = target_d & 32'hFFFF_FFFC;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StReset;
            pc_q       <= RESET_PC;
            inst_q     <= '0;
            retired_q  <= '0;
            req_q      <= 1'b0;
            valid_q    <= 1'b0;
`ifdef IF_MISALIGN_TRAP_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                StReset: begin
                    state_q <= StFetch;
                    req_q   <= 1'b1;
                end
                StFetch: begin
                    if (bus.imem_ack) begin
                        inst_q  <= bus.imem_rdata;
                        valid_q <= 1'b1;
                        req_q   <= 1'b0;
                        state_q <= StExec;
                    end
                end
                StExec: begin
                    if (!bus.stall) begin
                        pc_q      <= next_pc_d;
                        retired_q <= retired_q + 32'd1;
                        valid_q   <= 1'b0;
`ifdef IF_MISALIGN_TRAP_EN
                        if (next_pc_d[1:0] != 2'b00) begin
                            state_q    <= StTrap;
                            misalign_q <= 1'b1;
                            req_q      <= 1'b0;
                        end else begin
                            state_q <= StFetch;
                            req_q   <= 1'b1;
                        end
`else
                        state_q <= StFetch;
                        req_q   <= 1'b1;
`endif
                    end
                end
`ifdef IF_MISALIGN_TRAP_EN
                StTrap: begin
                    // Sticky until reset
                    req_q      <= 1'b0;
                    valid_q    <= 1'b0;
                    misalign_q <= 1'b1;
                end
`endif
                default: state_q <= StReset;
            endcase
        end
    end

    assign bus.imem_req   = req_q;
    assign bus.imem_addr  = pc_q;
    assign bus.pc         = pc_q;
    assign bus.inst       = inst_q;
    assign bus.opcode     = inst_q[6:0];
    assign bus.func3      = inst_q[14:12];
    assign bus.inst_valid = valid_q;
    assign bus.retired    = retired_q;
`ifdef IF_MISALIGN_TRAP_EN
    assign bus.misalign   = misalign_q;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: expected fetch addresses go to a scoreboard queue that a
// negedge monitor drains on every accepted request; state checks are made inline.
module tb_instr_fetch;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    int   exp_ret;
    logic [31:0] exp_inst;
    logic [31:0] sb_q[$];

    instr_fetch_if bus ();

    instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Monitor: every accepted fetch must match the next expected address.
    always @(negedge clk) begin
        if (!rst && bus.imem_req === 1'b1 && bus.imem_ack === 1'b1) begin
            total++;
            if (sb_q.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected: got fetch %h want none", bus.imem_addr);
            end else begin
                logic [31:0] e;
                e = sb_q.pop_front();
                if (bus.imem_addr !== e) begin
                    bad++;
                    $display("FAIL sb_addr: got %h want %h", bus.imem_addr, e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    // Entry/exit: just after a posedge with the DUT in FETCH.
    task automatic run_instr(input int waits, input logic [31:0] addr, input logic [31:0] word,
                             input logic b_eq, input logic b_ge, input logic z, input logic g,
                             input logic [31:0] imm, input int stalls);
        sb_q.push_back(addr);
        check("entry_req", {31'd0, bus.imem_req}, 32'd1);
        check("entry_valid", {31'd0, bus.inst_valid}, 32'd0);
        for (int i = 0; i < waits; i++) begin
            bus.imem_ack = 1'b0;
            @(posedge clk); #1;
            check("wait_req", {31'd0, bus.imem_req}, 32'd1);
            check("wait_addr", bus.imem_addr, addr);
            check("wait_inst", bus.inst, exp_inst);
        end
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = word;
        @(posedge clk); #1;
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = 32'hDEAD_BEEF;
        exp_inst = word;
        check("exec_valid", {31'd0, bus.inst_valid}, 32'd1);
        check("exec_inst", bus.inst, word);
        check("exec_req", {31'd0, bus.imem_req}, 32'd0);
        bus.beq   = b_eq;
        bus.bge   = b_ge;
        bus.zero  = z;
        bus.ge    = g;
        bus.imm_b = imm;
        bus.stall = (stalls > 0);
        for (int i = 0; i < stalls; i++) begin
            @(posedge clk); #1;
            check("stall_pc", bus.pc, addr);
            check("stall_inst", bus.inst, word);
            check("stall_ret", bus.retired, exp_ret);
            check("stall_req", {31'd0, bus.imem_req}, 32'd0);
            check("stall_valid", {31'd0, bus.inst_valid}, 32'd1);
        end
        bus.stall = 1'b0;
        @(posedge clk); #1;
        exp_ret++;
        check("retired", bus.retired, exp_ret);
        bus.beq  = 1'b0;
        bus.bge  = 1'b0;
        bus.zero = 1'b0;
        bus.ge   = 1'b0;
        bus.imm_b = 32'h0;
    endtask

    initial begin
        total = 0;
        bad = 0;
        exp_ret = 0;
        exp_inst = 32'h0;
        rst = 1'b1;
        bus.imem_ack = 1'b0;
        bus.imem_rdata = 32'h0;
        bus.stall = 1'b0;
        bus.beq = 1'b0;
        bus.bge = 1'b0;
        bus.zero = 1'b0;
        bus.ge = 1'b0;
        bus.imm_b = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req", {31'd0, bus.imem_req}, 32'd0);
        check("rst_addr", bus.imem_addr, 32'h0);
        check("rst_inst", bus.inst, 32'h0);
        check("rst_opcode", {25'd0, bus.opcode}, 32'h0);
        check("rst_func3", {29'd0, bus.func3}, 32'h0);
        check("rst_valid", {31'd0, bus.inst_valid}, 32'd0);
        check("rst_retired", bus.retired, 32'h0);
`ifdef IF_MISALIGN_TRAP_EN
        check("rst_misalign", {31'd0, bus.misalign}, 32'd0);
`endif
        rst = 1'b0;
        check("cyc0_req", {31'd0, bus.imem_req}, 32'd0);
        @(posedge clk); #1;
        check("cyc1_req", {31'd0, bus.imem_req}, 32'd1);

        // Four sequential words, zero-wait memory
        run_instr(0, 32'h0, 32'h0000_5013, 0, 0, 0, 0, 32'h0, 0);
        check("opcode", {25'd0, bus.opcode}, 32'h13);
        check("func3", {29'd0, bus.func3}, 32'h5);
        run_instr(0, 32'h4, 32'h0010_0093, 0, 0, 0, 0, 32'h0, 0);
        run_instr(0, 32'h8, 32'h0020_0113, 0, 0, 0, 0, 32'h0, 0);
        run_instr(0, 32'hC, 32'h0030_0193, 0, 0, 0, 0, 32'h0, 0);
        check("retired4", bus.retired, 32'd4);

        // Three wait cycles, then branches
        run_instr(3, 32'h10, 32'hFE00_0CE3, 1, 0, 1, 0, 32'hFFFF_FFF8, 0);
        run_instr(0, 32'h08, 32'h0000_0463, 1, 0, 1, 0, 32'h0000_0008, 0);
        run_instr(1, 32'h10, 32'hFE00_0CE3, 1, 0, 0, 0, 32'hFFFF_FFF8, 0);
        run_instr(0, 32'h14, 32'h0200_5063, 0, 1, 0, 1, 32'h0000_0020, 0);
        run_instr(0, 32'h34, 32'h0000_0063, 1, 1, 1, 0, 32'hFFFF_FFCC, 0);

        // Stall for 5 cycles, then wrap-around at the top of memory
        run_instr(0, 32'h0, 32'h0000_0013, 0, 0, 0, 0, 32'h0, 5);
        run_instr(0, 32'h4, 32'hFE00_5CE3, 0, 1, 0, 1, 32'hFFFF_FFF8, 0);
        run_instr(2, 32'hFFFF_FFFC, 32'h0000_0013, 0, 0, 0, 0, 32'h0, 0);
        check("wrap_addr", bus.imem_addr, 32'h0);

        // Reset mid-wait with an ack landing in the reset cycle
        bus.imem_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        bus.imem_ack = 1'b1;
        bus.imem_rdata = 32'h1234_5678;
        @(posedge clk); #1;
        bus.imem_ack = 1'b0;
        check("mid_rst_valid", {31'd0, bus.inst_valid}, 32'd0);
        check("mid_rst_pc", bus.pc, 32'h0);
        check("mid_rst_inst", bus.inst, 32'h0);
        check("mid_rst_ret", bus.retired, 32'h0);
        check("mid_rst_req", {31'd0, bus.imem_req}, 32'd0);
        exp_ret = 0;
        exp_inst = 32'h0;
        rst = 1'b0;
        @(posedge clk); #1;
        check("restart_addr", bus.imem_addr, 32'h0);

        // Misaligned branch target
        run_instr(0, 32'h0, 32'h0000_0363, 1, 0, 1, 0, 32'h0000_0006, 0);
`ifdef IF_MISALIGN_TRAP_EN
        check("trap_misalign", {31'd0, bus.misalign}, 32'd1);
        check("trap_pc", bus.pc, 32'h6);
        bus.imem_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("trap_req", {31'd0, bus.imem_req}, 32'd0);
            check("trap_valid", {31'd0, bus.inst_valid}, 32'd0);
        end
        bus.imem_ack = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("trap_clear", {31'd0, bus.misalign}, 32'd0);
`else
        check("align_addr", bus.imem_addr, 32'h4);
        run_instr(0, 32'h4, 32'h0000_0013, 0, 0, 0, 0, 32'h0, 0);
`endif
        @(posedge clk); #1;
        check("sb_drained", sb_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
